// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first: 2-flop input synchronizer, mid-bit sampling FSM,
// holding register with valid/ack handshake, framing-error and overrun pulses.
//
// state | meaning
// IDLE  | line idle, waiting for rxs to fall
// START | confirming the start bit at half-bit
// DATA  | sampling 8 data bits, one per bit period
// STOP  | sampling the stop bit; load holding register or flag ferr
// BREAK | stop bit was low; wait for the line to return high
module uart_rx #(
  parameter int BAUDRATE = 1250
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr,
  output logic       ovr
);

  localparam int CW = $clog2(BAUDRATE);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUDRATE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUDRATE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, rxs_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            tick;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q  <= 1'b1;
      rxs_q    <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync1_q  <= rx;
      rxs_q    <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  // START waits half a bit so every later tick lands mid-bit
  assign tick = (state_q == S_START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;

    if (ack && valid_q) valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          bitcnt_d = '0;
          state_d  = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d[bitcnt_q] = rxs_q;
          if (bitcnt_q == 3'd7) state_d = S_STOP;
          else                  bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rxs_q) begin
            // a completing frame wins over a same-cycle ack
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !ack;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign ferr  = ferr_q;
  assign ovr   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: frames driven on negedges, expected bytes
// queued at send time and compared when the receiver presents them.
module tb_uart_rx;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;

  int n_chk = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.BAUDRATE(BIT)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .rx    (rx),
    .ack   (ack),
    .data  (data),
    .valid (valid),
    .ferr  (ferr),
    .ovr   (ovr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (ovr) ovr_cnt <= ovr_cnt + 1;
    if (ferr && ovr) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pop_exp();
    logic [7:0] v;
    v = 8'hxx;
    if (exp_q.size() > 0) v = exp_q.pop_front();
    return v;
  endfunction

  // caller is at a negedge; returns at the negedge ending the stop bit
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hello [8];
    int f0, o0;
    hello = '{8'h2E, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h2E};

    rstn = 1'b0;
    rx   = 1'b1;
    ack  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_ferr", 32'(ferr), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single byte, latency from rx fall
    exp_q.push_back(8'h48);
    fork
      send_frame(8'h48, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 chk("t1_valid_early", 32'(valid), 32'd0);
        @(posedge clk);
        #1 chk("t1_valid_155", 32'(valid), 32'd1);
        chk("t1_data", 32'(data), 32'(pop_exp()));
      end
    join
    chk("t1_ferr", 32'(ferr_cnt), 32'd0);
    ack_pulse();
    chk("t1_ack_clears", 32'(valid), 32'd0);

    // 2: back-to-back string with a consumer acking each byte
    o0 = ovr_cnt;
    foreach (hello[i]) exp_q.push_back(hello[i]);
    fork
      foreach (hello[i]) send_frame(hello[i], 1'b1);
      for (int k = 0; k < 8; k++) begin
        int t;
        t = 0;
        while (!valid && t < 400) begin
          @(negedge clk);
          t++;
        end
        if (!valid) chk("t2_wait_valid", 32'd0, 32'd1);
        else chk("t2_data", 32'(data), 32'(pop_exp()));
        ack_pulse();
      end
    join
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_no_ovr", 32'(ovr_cnt - o0), 32'd0);

    // 3: short glitch on an idle line
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("t3_valid", 32'(valid), 32'd0);
    chk("t3_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 4: low stop bit, then a clean frame
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    chk("t4_valid", 32'(valid), 32'd0);
    chk("t4_data_kept", 32'(data), 32'h2E);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    chk("t4_next_valid", 32'(valid), 32'd1);
    chk("t4_next_data", 32'(data), 32'(pop_exp()));
    chk("t4_next_ferr", 32'(ferr_cnt - f0), 32'd1);
    ack_pulse();

    // 5a: overrun without ack
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    void'(pop_exp());
    chk("t5_ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
    chk("t5_valid", 32'(valid), 32'd1);
    chk("t5_data", 32'(data), 32'(pop_exp()));
    ack_pulse();

    // 5b: ack lands on the completion edge of the second frame
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (154) @(negedge clk);
        chk("t5b_first", 32'(data), 32'(pop_exp()));
        ack_pulse();
        chk("t5b_valid", 32'(valid), 32'd1);
        chk("t5b_data", 32'(data), 32'(pop_exp()));
      end
    join
    chk("t5b_no_ovr", 32'(ovr_cnt - o0), 32'd0);

    // 6: async reset in the middle of a frame while a byte is still held
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (60) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(valid), 32'd0);
        chk("t6_rst_data", 32'(data), 32'h00);
        chk("t6_rst_flags", 32'({ferr, ovr}), 32'd0);
      end
    join
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    chk("t6_valid", 32'(valid), 32'd1);
    chk("t6_data", 32'(data), 32'(pop_exp()));
    ack_pulse();

    chk("never_both", 32'(both_cnt), 32'd0);
    chk("sb_final_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
